// File: rtl/jtdd_rom_pkg.sv
// Shared types and helpers for the character ROM fetch slot.
package jtdd_rom_pkg;

  localparam int unsigned SdramDw = 32;
  localparam int unsigned SdramAw = 22;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } rom_st_e;

  // Pick one byte out of a 32-bit SDRAM word; byte 0 sits in bits [7:0].
  function automatic logic [7:0] byte_sel(input logic [SdramDw-1:0] word,
                                          input logic [1:0]         sel);
    return word[{sel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/jtdd_rom_buf.sv
// One cached SDRAM word: tag, data, valid flag, tag compare and fill port.
// With JTDD_ROM_PREFETCH_EN a second compare port lets the slot ask whether
// a prefetch candidate is already held.
module jtdd_rom_buf
  import jtdd_rom_pkg::*;
#(
  parameter int unsigned TW = 13
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               fill_i,
  input  logic [TW-1:0]      fill_tag_i,
  input  logic [SdramDw-1:0] fill_data_i,
  input  logic [TW-1:0]      look_tag_i,
  output logic               hit_o,
  output logic [SdramDw-1:0] data_o
`ifdef JTDD_ROM_PREFETCH_EN
  ,
  input  logic [TW-1:0]      probe_tag_i,
  output logic               probe_hit_o
`endif
);

  logic               valid_q;
  logic [TW-1:0]      tag_q;
  logic [SdramDw-1:0] data_q;

  // Clear drops the contents; a fill overwrites tag and data together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag_i;
      data_q  <= fill_data_i;
    end
  end

  assign hit_o  = valid_q && (tag_q == look_tag_i);
  assign data_o = data_q;

`ifdef JTDD_ROM_PREFETCH_EN
  assign probe_hit_o = valid_q && (tag_q == probe_tag_i);
`endif

endmodule

// File: rtl/jtdd_rom_slot.sv
// Character ROM fetch slot: converts byte addresses into 32-bit SDRAM word
// fetches, caches the word and returns the addressed byte with a valid flag.
// Optional macro JTDD_ROM_PREFETCH_EN adds a second buffer and a tag+1 prefetch.
module jtdd_rom_slot
  import jtdd_rom_pkg::*;
#(
  parameter int unsigned AW     = 15,
  parameter logic [21:0] OFFSET = 22'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               downloading,
  input  logic [AW-1:0]      addr,
  input  logic               addr_ok,
  output logic [7:0]         dout,
  output logic               ok,
  output logic               sdram_req,
  output logic [SdramAw-1:0] sdram_addr,
  input  logic               sdram_ack,
  input  logic               data_rdy,
  input  logic [SdramDw-1:0] data_read
);

  localparam int unsigned TW = AW - 2;

  // Tag t covers two 16-bit SDRAM words starting at OFFSET + 2t.
  function automatic logic [SdramAw-1:0] word_addr(input logic [TW-1:0] t);
    return OFFSET + SdramAw'({t, 1'b0});
  endfunction

  rom_st_e            state_q, state_d;
  logic               req_q, req_d;
  logic [SdramAw-1:0] saddr_q, saddr_d;
  logic [TW-1:0]      ftag_q, ftag_d;
  logic [TW-1:0]      cur_tag;
  logic               fill;
  logic               hit;
  logic [SdramDw-1:0] hit_data;
  logic               ok_q;
  logic [7:0]         dout_q;

  assign cur_tag = addr[AW-1:2];

  // Data is taken in WAIT, or in REQ when ack and data coincide.
  assign fill = data_rdy && !downloading &&
                ((state_q == StWait) || ((state_q == StReq) && sdram_ack));

`ifdef JTDD_ROM_PREFETCH_EN
  logic               hit0, hit1, phit0, phit1, tgt;
  logic [SdramDw-1:0] data0, data1;
  logic               vic_q;
  logic               pf_pend_q, pf_pend_d;
  logic [TW-1:0]      pf_tag_q, pf_tag_d;
  logic               is_pf_q, is_pf_d;

  // Never overwrite the buffer serving the current address; else alternate.
  assign tgt = (hit0 && !hit1) ? 1'b1 : ((hit1 && !hit0) ? 1'b0 : vic_q);

  jtdd_rom_buf #(.TW(TW)) u_buf0 (
    .clk_i      (clk),
    .rst_ni     (rst),
    .clr_i      (downloading),
    .fill_i     (fill && !tgt),
    .fill_tag_i (ftag_q),
    .fill_data_i(data_read),
    .look_tag_i (cur_tag),
    .hit_o      (hit0),
    .data_o     (data0),
    .probe_tag_i(pf_tag_q),
    .probe_hit_o(phit0)
  );

  jtdd_rom_buf #(.TW(TW)) u_buf1 (
    .clk_i      (clk),
    .rst_ni     (rst),
    .clr_i      (downloading),
    .fill_i     (fill && tgt),
    .fill_tag_i (ftag_q),
    .fill_data_i(data_read),
    .look_tag_i (cur_tag),
    .hit_o      (hit1),
    .data_o     (data1),
    .probe_tag_i(pf_tag_q),
    .probe_hit_o(phit1)
  );

  assign hit      = hit0 || hit1;
  assign hit_data = hit1 ? data1 : data0;

  // Prefetch bookkeeping and replacement pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vic_q     <= 1'b0;
      pf_pend_q <= 1'b0;
      pf_tag_q  <= '0;
      is_pf_q   <= 1'b0;
    end else begin
      if (fill) vic_q <= ~tgt;
      pf_pend_q <= pf_pend_d;
      pf_tag_q  <= pf_tag_d;
      is_pf_q   <= is_pf_d;
    end
  end
`else
  jtdd_rom_buf #(.TW(TW)) u_buf0 (
    .clk_i      (clk),
    .rst_ni     (rst),
    .clr_i      (downloading),
    .fill_i     (fill),
    .fill_tag_i (ftag_q),
    .fill_data_i(data_read),
    .look_tag_i (cur_tag),
    .hit_o      (hit),
    .data_o     (hit_data)
  );
`endif

  // Fetch FSM next state: one outstanding request, never aborted except by download.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    saddr_d = saddr_q;
    ftag_d  = ftag_q;
`ifdef JTDD_ROM_PREFETCH_EN
    pf_pend_d = pf_pend_q;
    pf_tag_d  = pf_tag_q;
    is_pf_d   = is_pf_q;
    if (fill && !is_pf_q) begin
      pf_pend_d = 1'b1;
      pf_tag_d  = ftag_q + {{(TW-1){1'b0}}, 1'b1};
    end
`endif
    if (downloading) begin
      state_d = StIdle;
      req_d   = 1'b0;
`ifdef JTDD_ROM_PREFETCH_EN
      pf_pend_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (addr_ok && !hit) begin
            ftag_d  = cur_tag;
            saddr_d = word_addr(cur_tag);
            req_d   = 1'b1;
            state_d = StReq;
`ifdef JTDD_ROM_PREFETCH_EN
            is_pf_d = 1'b0;
          end else if (pf_pend_q && addr_ok) begin
            pf_pend_d = 1'b0;
            if (!(phit0 || phit1)) begin
              ftag_d  = pf_tag_q;
              saddr_d = word_addr(pf_tag_q);
              req_d   = 1'b1;
              state_d = StReq;
              is_pf_d = 1'b1;
            end
`endif
          end
        end
        StReq: begin
          if (sdram_ack) begin
            req_d   = 1'b0;
            state_d = data_rdy ? StIdle : StWait;
          end
        end
        StWait: begin
          if (data_rdy) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM and request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      saddr_q <= OFFSET;
      ftag_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      saddr_q <= saddr_d;
      ftag_q  <= ftag_d;
    end
  end

  // Registered consumer outputs: one cycle after the address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ok_q   <= 1'b0;
      dout_q <= 8'h00;
    end else begin
      ok_q   <= addr_ok && hit && !downloading;
      dout_q <= byte_sel(hit_data, addr[1:0]);
    end
  end

  assign ok         = ok_q;
  assign dout       = dout_q;
  assign sdram_req  = req_q;
  assign sdram_addr = saddr_q;

endmodule

// File: tb/tb_jtdd_rom_slot.sv
// Bench for jtdd_rom_slot: directed protocol steps plus a randomized run
// against an SDRAM responder whose memory content is a fixed hash of address.
module tb_jtdd_rom_slot;

  localparam logic [21:0] OFF = 22'h100;

  logic        clk, rst, downloading, addr_ok, ok, sdram_req, sdram_ack, data_rdy;
  logic [14:0] addr;
  logic [7:0]  dout;
  logic [21:0] sdram_addr;
  logic [31:0] data_read;

  int tests = 0;
  int fails = 0;

  // responder state
  logic        auto_resp;
  int          rs, cnt;
  logic [21:0] lat;
  logic [14:0] prev_addr;
  logic        prev_aok, prev_dl;

  jtdd_rom_slot #(.AW(15), .OFFSET(OFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .downloading(downloading),
    .addr       (addr),
    .addr_ok    (addr_ok),
    .dout       (dout),
    .ok         (ok),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .data_rdy   (data_rdy),
    .data_read  (data_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [21:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  // Expected byte: word at OFFSET + 2*(addr/4), byte addr%4.
  function automatic logic [7:0] exp_byte(input logic [14:0] a);
    logic [21:0] sa;
    logic [31:0] w;
    sa = OFF + 22'(a >> 2) * 22'd2;
    w  = mem_word(sa);
    return w[8*a[1:0] +: 8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic respond();
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    if (downloading) begin
      rs = 0;
    end else begin
      if (rs == 0 && sdram_req) begin
        lat = sdram_addr;
        chk("req_even", 32'(sdram_addr[0]), 32'd0);
        cnt = int'($urandom_range(0, 3));
        rs  = 1;
      end
      if (rs == 1) begin
        if (!sdram_req) rs = 0;
        else begin
          chk("req_stable", sdram_addr, lat);
          if (cnt == 0) begin
            sdram_ack = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
              data_rdy  = 1'b1;
              data_read = mem_word(lat);
              rs        = 0;
            end else begin
              rs  = 2;
              cnt = int'($urandom_range(0, 3));
            end
          end else cnt--;
        end
      end else if (rs == 2) begin
        chk("one_outstanding", sdram_req, 0);
        if (cnt == 0) begin
          data_rdy  = 1'b1;
          data_read = mem_word(lat);
          rs        = 0;
        end else cnt--;
      end
    end
  endtask

  task automatic cycle();
    if (auto_resp) respond();
    prev_addr = addr;
    prev_aok  = addr_ok;
    prev_dl   = downloading;
    @(posedge clk);
    #1;
    if (auto_resp && ok) begin
      chk("ok_data", dout, exp_byte(prev_addr));
      chk("ok_qual", {prev_aok, prev_dl}, 2'b10);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; addr_ok = 1'b0; downloading = 1'b0; addr = '0;
    sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
    auto_resp = 1'b0; rs = 0; cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    lat = '0;
    do_reset();
    chk("rst_ok", ok, 0);
    chk("rst_dout", dout, 0);
    chk("rst_req", sdram_req, 0);
    chk("rst_saddr", sdram_addr, OFF);
    for (int i = 0; i < 20; i++) begin
      addr = 15'($urandom_range(0, 32767));
      cycle();
      chk("idle_req", sdram_req, 0);
    end
    chk("idle_ok", ok, 0);
    chk("idle_dout", dout, 0);

`ifdef JTDD_ROM_PREFETCH_EN
    // Prefetch across the tag wrap.
    do_reset();
    addr = 15'h7FFC; addr_ok = 1'b1;
    cycle();
    chk("pf_dem_req", sdram_req, 1);
    chk("pf_dem_addr", sdram_addr, OFF + 22'h3FFE);
    sdram_ack = 1'b1; cycle(); sdram_ack = 1'b0;
    data_rdy = 1'b1; data_read = 32'h44332211; cycle(); data_rdy = 1'b0;
    for (int i = 0; i < 10 && !sdram_req; i++) cycle();
    chk("pf_req", sdram_req, 1);
    chk("pf_addr", sdram_addr, OFF);
    chk("pf_dem_ok", ok, 1);
    chk("pf_dem_dout", dout, 8'h11);
    sdram_ack = 1'b1; cycle(); sdram_ack = 1'b0;
    data_rdy = 1'b1; data_read = 32'h99887766; cycle(); data_rdy = 1'b0;
    cycle();
    addr = 15'h0000;
    cycle();
    chk("pf_hit_ok", ok, 1);
    chk("pf_hit_dout", dout, 8'h66);
    chk("pf_hit_noreq", sdram_req, 0);
`else
    // Basic miss then hits.
    do_reset();
    addr = 15'h0005; addr_ok = 1'b1;
    cycle();
    chk("miss_req", sdram_req, 1);
    chk("miss_addr", sdram_addr, 22'h102);
    repeat (2) cycle();
    chk("req_hold", sdram_req, 1);
    chk("req_hold_addr", sdram_addr, 22'h102);
    sdram_ack = 1'b1; cycle(); sdram_ack = 1'b0;
    chk("ack_drop", sdram_req, 0);
    cycle();
    data_rdy = 1'b1; data_read = 32'hDDCCBBAA; cycle(); data_rdy = 1'b0;
    chk("fill_ok_d1", ok, 0);
    cycle();
    chk("fill_ok_d2", ok, 1);
    chk("fill_dout", dout, 8'hBB);
    addr = 15'h0006; cycle();
    chk("hit6_ok", ok, 1);
    chk("hit6_dout", dout, 8'hCC);
    chk("hit6_noreq", sdram_req, 0);
    addr = 15'h0007; cycle();
    chk("hit7_ok", ok, 1);
    chk("hit7_dout", dout, 8'hDD);
    chk("hit7_noreq", sdram_req, 0);

    // Address change while waiting for data.
    do_reset();
    addr = 15'h0004; addr_ok = 1'b1;
    cycle();
    chk("chg_req1", sdram_addr, 22'h102);
    sdram_ack = 1'b1; cycle(); sdram_ack = 1'b0;
    addr = 15'h0040;
    cycle(); chk("chg_ok_a", ok, 0);
    cycle(); chk("chg_ok_b", ok, 0);
    data_rdy = 1'b1; data_read = 32'h11223344; cycle(); data_rdy = 1'b0;
    chk("chg_ok_c", ok, 0);
    chk("chg_noreq", sdram_req, 0);
    cycle();
    chk("chg_req2", sdram_req, 1);
    chk("chg_addr2", sdram_addr, OFF + 22'h20);
    chk("chg_ok_d", ok, 0);
    sdram_ack = 1'b1; cycle(); sdram_ack = 1'b0;
    chk("chg_ok_e", ok, 0);
    data_rdy = 1'b1; data_read = 32'h55667788; cycle(); data_rdy = 1'b0;
    chk("chg_ok_f", ok, 0);
    cycle();
    chk("chg_ok_g", ok, 1);
    chk("chg_dout", dout, 8'h88);

    // Download aborts a request; same-cycle ack and data afterwards.
    do_reset();
    addr = 15'h0008; addr_ok = 1'b1;
    cycle();
    chk("dl_req", sdram_req, 1);
    chk("dl_addr", sdram_addr, 22'h104);
    downloading = 1'b1; cycle();
    chk("dl_req_drop", sdram_req, 0);
    chk("dl_ok", ok, 0);
    data_rdy = 1'b1; data_read = 32'hCAFEBABE; cycle(); data_rdy = 1'b0;
    chk("dl_late_ok", ok, 0);
    chk("dl_late_req", sdram_req, 0);
    downloading = 1'b0; cycle();
    chk("dl_rereq", sdram_req, 1);
    chk("dl_readdr", sdram_addr, 22'h104);
    sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 32'h0A0B0C0D;
    cycle();
    sdram_ack = 1'b0; data_rdy = 1'b0;
    chk("combo_req", sdram_req, 0);
    chk("combo_ok1", ok, 0);
    cycle();
    chk("combo_ok2", ok, 1);
    chk("combo_dout", dout, 8'h0D);
`endif

    // Randomized run against the memory model.
    do_reset();
    auto_resp = 1'b1;
    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 1) == 1) addr = 15'($urandom_range(0, 23));
      else addr = 15'(15'h7FF0 + 15'($urandom_range(0, 15)));
      addr_ok     = ($urandom_range(0, 4) != 0);
      downloading = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) cycle();
      if (seg % 5 == 4) begin
        addr_ok = 1'b1; downloading = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) cycle();
        chk("live_ok", ok, 1);
        if (ok) chk("live_dout", dout, exp_byte(addr));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
